// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the control-vector bit positions, the MEM_SIZE encodings and the
// FSM state encoding used by mem_access_stage and load_store_align.
package mips_mem_pkg;

  // Control vector bit positions
  localparam int MEM_READ    = 0;
  localparam int MEM_WRITE   = 1;
  localparam int MEM_SIZE_LO = 2;
  localparam int MEM_SIZE_HI = 3;
  localparam int MEM_SIGNED  = 4;
  localparam int REG_WRITE   = 5;

  // MEM_SIZE encodings; 2'b11 behaves as a word access
  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } mem_size_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic for the MEM stage.
// Store side: byte enables, lane-replicated write data and the alignment
//   check for the access currently presented by EX/MEM.
// Load side: lane selection from the returned memory word and sign/zero
//   extension, driven by the attributes latched when the access started.
// Ports:
//   st_addr_lo, st_size, st_data -> st_be, st_wdata, misaligned
//   ld_addr_lo, ld_size, ld_signed, ld_rdata -> ld_data
module load_store_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  mem_size_e   st_size,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        misaligned,
  input  logic [1:0]  ld_addr_lo,
  input  mem_size_e   ld_size,
  input  logic        ld_signed,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  function automatic logic [31:0] extend8(input logic [7:0] b, input logic sgn);
    logic signed [31:0] r;
    r = {{24{b[7] & sgn}}, b};
    return r;
  endfunction

  function automatic logic [31:0] extend16(input logic [15:0] h, input logic sgn);
    logic signed [31:0] r;
    r = {{16{h[15] & sgn}}, h};
    return r;
  endfunction

  always_comb begin
    st_be      = 4'b1111;
    st_wdata   = st_data;
    misaligned = 1'b0;
    case (st_size)
      SIZE_BYTE: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SIZE_HALF: begin
        st_be      = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata   = {2{st_data[15:0]}};
        misaligned = st_addr_lo[0];
      end
      default: begin
        misaligned = (st_addr_lo != 2'b00);
      end
    endcase
  end

  always_comb begin
    ld_data = ld_rdata;
    case (ld_size)
      SIZE_BYTE: ld_data = extend8(ld_rdata[{ld_addr_lo, 3'b000} +: 8], ld_signed);
      SIZE_HALF: ld_data = extend16(ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0], ld_signed);
      default:   ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues byte/half/word loads and stores on a req/ack
// data-memory port, stalls upstream while an access is outstanding, and
// produces the registered MEM/WB bundle.
// Ports:
//   clk, reset (async, active-low)
//   EX/MEM inputs : in_valid, control_signals_in, alu_result_in, pb_in,
//                   destination_in
//   stall_out     : holds EX/MEM and earlier stages
//   dmem_*        : req/we/addr/be/wdata out, rdata/ack in
//   MEM/WB        : wb_valid_out, wb_control_out, wb_data_out,
//                   wb_destination_out
//   align_fault_out, bus_error_out : one-cycle fault pulses
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CTRL_W      = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] control_signals_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       pb_in,
  input  logic [4:0]        destination_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [31:0]       dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid_out,
  output logic [CTRL_W-1:0] wb_control_out,
  output logic [31:0]       wb_data_out,
  output logic [4:0]        wb_destination_out,
  output logic              align_fault_out,
  output logic              bus_error_out
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CTRL_W-1:0] REG_WRITE_MASK = ~(CTRL_W'(1) << REG_WRITE);

  mem_state_e        state, state_nxt;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [31:0]       alu_p1;
  logic [4:0]        dest_p1;

  logic        mem_op, start, fault, timeout_hit;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;
  logic        misaligned;

  assign mem_op = control_signals_in[MEM_READ] | control_signals_in[MEM_WRITE];

  // Abort on the edge that closes the ACK_TIMEOUT-th unacknowledged cycle;
  // an ack in that same cycle takes priority.
  assign timeout_hit = (state == WAIT_ACK) && !dmem_ack &&
                       (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1));

  load_store_align u_align (
    .st_addr_lo (alu_result_in[1:0]),
    .st_size    (mem_size_e'(control_signals_in[MEM_SIZE_HI:MEM_SIZE_LO])),
    .st_data    (pb_in),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .misaligned (misaligned),
    .ld_addr_lo (alu_p1[1:0]),
    .ld_size    (mem_size_e'(ctrl_p1[MEM_SIZE_HI:MEM_SIZE_LO])),
    .ld_signed  (ctrl_p1[MEM_SIGNED]),
    .ld_rdata   (dmem_rdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_out = 1'b0;
    start     = 1'b0;
    fault     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && mem_op) begin
          if (misaligned) begin
            fault = 1'b1;
          end else begin
            stall_out = 1'b1;
            start     = 1'b1;
            state_nxt = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        // Release on the completing edge so EX/MEM advances with it
        stall_out = !(dmem_ack || timeout_hit);
        if (dmem_ack || timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_cnt <= '0;
    else if (state == WAIT_ACK && !dmem_ack && !timeout_hit) tmo_cnt <= tmo_cnt + CNT_W'(1);
    else tmo_cnt <= '0;
  end

  // ---- MEM/WB boundary: request issue, access attributes, writeback bundle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_req           <= 1'b0;
      dmem_we            <= 1'b0;
      dmem_addr          <= '0;
      dmem_be            <= '0;
      dmem_wdata         <= '0;
      ctrl_p1            <= '0;
      alu_p1             <= '0;
      dest_p1            <= '0;
      wb_valid_out       <= 1'b0;
      wb_control_out     <= '0;
      wb_data_out        <= '0;
      wb_destination_out <= '0;
      align_fault_out    <= 1'b0;
      bus_error_out      <= 1'b0;
    end else begin
      align_fault_out <= 1'b0;
      bus_error_out   <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          dmem_req     <= 1'b1;
          dmem_we      <= control_signals_in[MEM_WRITE];
          dmem_addr    <= {alu_result_in[31:2], 2'b00};
          dmem_be      <= st_be;
          dmem_wdata   <= st_wdata;
          ctrl_p1      <= control_signals_in;
          alu_p1       <= alu_result_in;
          dest_p1      <= destination_in;
          wb_valid_out <= 1'b0;
        end else begin
          wb_valid_out       <= in_valid;
          wb_control_out     <= fault ? (control_signals_in & REG_WRITE_MASK) : control_signals_in;
          wb_data_out        <= alu_result_in;
          wb_destination_out <= destination_in;
          align_fault_out    <= fault;
        end
      end else if (dmem_ack) begin
        dmem_req           <= 1'b0;
        wb_valid_out       <= 1'b1;
        wb_control_out     <= ctrl_p1;
        wb_data_out        <= dmem_we ? alu_p1 : ld_data;
        wb_destination_out <= dest_p1;
      end else if (timeout_hit) begin
        dmem_req           <= 1'b0;
        bus_error_out      <= 1'b1;
        wb_valid_out       <= 1'b1;
        wb_control_out     <= ctrl_p1 & REG_WRITE_MASK;
        wb_data_out        <= alu_p1;
        wb_destination_out <= dest_p1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int TMO = 16;
  localparam int CW  = 25;

  logic          clk, reset, in_valid;
  logic [CW-1:0] control_signals_in;
  logic [31:0]   alu_result_in, pb_in;
  logic [4:0]    destination_in;
  logic          stall_out, dmem_req, dmem_we;
  logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]    dmem_be;
  logic          dmem_ack;
  logic          wb_valid_out;
  logic [CW-1:0] wb_control_out;
  logic [31:0]   wb_data_out;
  logic [4:0]    wb_destination_out;
  logic          align_fault_out, bus_error_out;

  mem_access_stage #(.ACK_TIMEOUT(TMO), .CTRL_W(CW)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .control_signals_in (control_signals_in),
    .alu_result_in      (alu_result_in),
    .pb_in              (pb_in),
    .destination_in     (destination_in),
    .stall_out          (stall_out),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_be            (dmem_be),
    .dmem_wdata         (dmem_wdata),
    .dmem_rdata         (dmem_rdata),
    .dmem_ack           (dmem_ack),
    .wb_valid_out       (wb_valid_out),
    .wb_control_out     (wb_control_out),
    .wb_data_out        (wb_data_out),
    .wb_destination_out (wb_destination_out),
    .align_fault_out    (align_fault_out),
    .bus_error_out      (bus_error_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Control encodings: bit0 rd, bit1 wr, bits3:2 size, bit4 signed, bit5 reg_write
  localparam logic [CW-1:0] RW = 25'h20;

  typedef struct {
    logic          vld;
    logic [CW-1:0] ctrl;
    logic [31:0]   alu;
    logic [4:0]    dest;
    logic          exp_vld;
    logic [CW-1:0] exp_ctrl;
    logic          exp_fault;
  } vec_t;

  vec_t vt[7];

  // One memory access from IDLE; ack_cyc = WAIT_ACK cycle carrying the ack (0 = never)
  task automatic run_mem(input string nm, input logic [CW-1:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] pb, input logic [31:0] rdata, input int ack_cyc,
                         input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_data);
    logic [31:0] exp_addr;
    logic        done, err;
    exp_addr = {addr[31:2], 2'b00};
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; control_signals_in = ctrl; alu_result_in = addr;
    pb_in = pb; destination_in = 5'd9;
    #1 chk({nm, " stall_idle"}, {31'b0, stall_out}, 32'd1);
    @(posedge clk); #1;
    chk({nm, " req"},   {31'b0, dmem_req}, 32'd1);
    chk({nm, " we"},    {31'b0, dmem_we}, {31'b0, exp_we});
    chk({nm, " addr"},  dmem_addr, exp_addr);
    chk({nm, " be"},    {28'b0, dmem_be}, {28'b0, exp_be});
    if (exp_we) chk({nm, " wdata"}, dmem_wdata, exp_wdata);
    chk({nm, " bubble"}, {31'b0, wb_valid_out}, 32'd0);
    for (int c = 1; c <= TMO && !done; c++) begin
      @(negedge clk);
      if (c == ack_cyc) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
      else dmem_rdata = 32'h5A5A_5A5A;
      #1;
      chk({nm, " req_held"},  {31'b0, dmem_req}, 32'd1);
      chk({nm, " addr_held"}, dmem_addr, exp_addr);
      chk({nm, " stall"}, {31'b0, stall_out}, (c == ack_cyc || c == TMO) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (c == ack_cyc || c == TMO) begin
        done = 1'b1;
        err  = (c != ack_cyc);
        chk({nm, " req_drop"}, {31'b0, dmem_req}, 32'd0);
        chk({nm, " wb_valid"}, {31'b0, wb_valid_out}, 32'd1);
        chk({nm, " wb_data"},  wb_data_out, err ? addr : exp_data);
        chk({nm, " wb_ctrl"},  {7'b0, wb_control_out}, {7'b0, err ? (ctrl & ~RW) : ctrl});
        chk({nm, " wb_dest"},  {27'b0, wb_destination_out}, 32'd9);
        chk({nm, " bus_err"},  {31'b0, bus_error_out}, {31'b0, err});
      end
    end
    if (!done) begin
      failures++;
      $display("FAIL %s: access never completed", nm);
    end
    @(negedge clk);
    in_valid = 1'b0; control_signals_in = '0;
    @(posedge clk); #1;
    chk({nm, " err_pulse"}, {31'b0, bus_error_out}, 32'd0);
    chk({nm, " idle_req"},  {31'b0, dmem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; control_signals_in = '0; alu_result_in = '0;
    pb_in = '0; destination_in = '0; dmem_rdata = '0; dmem_ack = 1'b0;

    // vld, ctrl, alu, dest, exp_vld, exp_ctrl, exp_fault
    vt[0] = '{1'b1, 25'h1000020, 32'h0000_1234, 5'd7,  1'b1, 25'h1000020, 1'b0}; // ALU op
    vt[1] = '{1'b0, 25'h0000029, 32'h0000_0500, 5'd2,  1'b0, 25'h0000029, 1'b0}; // invalid slot
    vt[2] = '{1'b1, 25'h0000029, 32'h0000_0301, 5'd4,  1'b1, 25'h0000009, 1'b1}; // lw misaligned
    vt[3] = '{1'b1, 25'h0000035, 32'h0000_0203, 5'd5,  1'b1, 25'h0000015, 1'b1}; // lh odd
    vt[4] = '{1'b1, 25'h000000A, 32'h0000_0102, 5'd6,  1'b1, 25'h000000A, 1'b1}; // sw misaligned
    vt[5] = '{1'b1, 25'h000002D, 32'h0000_0302, 5'd8,  1'b1, 25'h000000D, 1'b1}; // size 11 misaligned
    vt[6] = '{1'b1, 25'h0800020, 32'hDEAD_BEEF, 5'd31, 1'b1, 25'h0800020, 1'b0}; // ALU op

    repeat (2) @(posedge clk);
    #1;
    chk("rst req",      {31'b0, dmem_req}, 32'd0);
    chk("rst wb_valid", {31'b0, wb_valid_out}, 32'd0);
    chk("rst wb_data",  wb_data_out, 32'd0);
    chk("rst wb_ctrl",  {7'b0, wb_control_out}, 32'd0);
    chk("rst stall",    {31'b0, stall_out}, 32'd0);
    chk("rst faults",   {30'b0, align_fault_out, bus_error_out}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = vt[i].vld; control_signals_in = vt[i].ctrl;
      alu_result_in = vt[i].alu; destination_in = vt[i].dest; pb_in = 32'h1111_2222;
      #1 chk($sformatf("vec%0d stall", i), {31'b0, stall_out}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d wb_valid", i), {31'b0, wb_valid_out}, {31'b0, vt[i].exp_vld});
      chk($sformatf("vec%0d wb_data", i),  wb_data_out, vt[i].alu);
      chk($sformatf("vec%0d wb_ctrl", i),  {7'b0, wb_control_out}, {7'b0, vt[i].exp_ctrl});
      chk($sformatf("vec%0d wb_dest", i),  {27'b0, wb_destination_out}, {27'b0, vt[i].dest});
      chk($sformatf("vec%0d align", i),    {31'b0, align_fault_out}, {31'b0, vt[i].exp_fault});
      chk($sformatf("vec%0d req", i),      {31'b0, dmem_req}, 32'd0);
    end

    @(negedge clk);
    in_valid = 1'b0; control_signals_in = '0;
    @(posedge clk); #1;
    chk("align pulse ends", {31'b0, align_fault_out}, 32'd0);
    chk("idle wb_valid",    {31'b0, wb_valid_out}, 32'd0);

    // stray ack while idle must be ignored
    @(negedge clk);
    dmem_ack = 1'b1;
    #1 chk("late ack stall", {31'b0, stall_out}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late ack req",      {31'b0, dmem_req}, 32'd0);
    chk("late ack wb_valid", {31'b0, wb_valid_out}, 32'd0);
    chk("late ack bus_err",  {31'b0, bus_error_out}, 32'd0);

    //       name       ctrl         addr          pb            rdata         ack we   be       wdata         exp_data
    run_mem("sb",      25'h0000002, 32'h0000_0103, 32'hAABB_CCDD, 32'h0,        3,  1'b1, 4'b1000, 32'hDDDD_DDDD, 32'h0000_0103);
    run_mem("lh_s",    25'h0000035, 32'h0000_0202, 32'h0,        32'h8001_0000, 1,  1'b0, 4'b1100, 32'h0,        32'hFFFF_8001);
    run_mem("lh_u",    25'h0000025, 32'h0000_0202, 32'h0,        32'h8001_0000, 1,  1'b0, 4'b1100, 32'h0,        32'h0000_8001);
    run_mem("lb_s",    25'h0000031, 32'h0000_0401, 32'h0,        32'h1234_8056, 1,  1'b0, 4'b0010, 32'h0,        32'hFFFF_FF80);
    run_mem("lbu",     25'h0000021, 32'h0000_0403, 32'h0,        32'h9A34_8056, 2,  1'b0, 4'b1000, 32'h0,        32'h0000_009A);
    run_mem("lw",      25'h0000029, 32'h0000_0500, 32'h0,        32'hCAFE_F00D, 2,  1'b0, 4'b1111, 32'h0,        32'hCAFE_F00D);
    run_mem("sh",      25'h0000006, 32'h0000_0106, 32'h1234_ABCD, 32'h0,        1,  1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0000_0106);
    run_mem("sw",      25'h100000A, 32'h0000_0108, 32'h1122_3344, 32'h0,        1,  1'b1, 4'b1111, 32'h1122_3344, 32'h0000_0108);
    run_mem("rd+wr",   25'h000000B, 32'h0000_010C, 32'h5566_7788, 32'h0,        1,  1'b1, 4'b1111, 32'h5566_7788, 32'h0000_010C);
    run_mem("timeout", 25'h0000029, 32'h0000_0600, 32'h0,        32'h0,        0,  1'b0, 4'b1111, 32'h0,        32'h0);
    run_mem("ack16",   25'h0000029, 32'h0000_0604, 32'h0,        32'h0BAD_F00D, 16, 1'b0, 4'b1111, 32'h0,        32'h0BAD_F00D);

    // asynchronous reset while an access is outstanding
    @(negedge clk);
    in_valid = 1'b1; control_signals_in = 25'h0000029; alu_result_in = 32'h0000_0700;
    destination_in = 5'd12;
    @(posedge clk); #1;
    chk("mid req_up", {31'b0, dmem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async req",      {31'b0, dmem_req}, 32'd0);
    chk("async addr",     dmem_addr, 32'd0);
    chk("async be",       {28'b0, dmem_be}, 32'd0);
    chk("async wb_valid", {31'b0, wb_valid_out}, 32'd0);
    chk("async wb_data",  wb_data_out, 32'd0);
    chk("async wb_ctrl",  {7'b0, wb_control_out}, 32'd0);
    chk("async wb_dest",  {27'b0, wb_destination_out}, 32'd0);
    in_valid = 1'b0; control_signals_in = '0;
    @(negedge clk);
    reset = 1'b1;
    run_mem("post_rst", 25'h0000029, 32'h0000_0704, 32'h0, 32'h7654_3210, 1, 1'b0, 4'b1111, 32'h0, 32'h7654_3210);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
